// File: rtl/wbs_mem_burst.sv
// Wishbone B3 slave RAM: byte-lane writes, optional wait states, registered-feedback
// incrementing/wrapping bursts, and an error response for misses or empty selects.
module wbs_mem_burst #(
  parameter int unsigned     DW          = 32,
  parameter int unsigned     AW          = 32,
  parameter int unsigned     DEPTH_LOG2  = 14,
  parameter longint unsigned BASE_ADR    = 0,
  parameter int unsigned     WAIT_STATES = 0,
  parameter int unsigned     BURST_EN    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o,
  input  logic            we_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic [2:0]      cti_i,
  input  logic [1:0]      bte_i,
  output logic            ack_o,
  output logic            err_o,
  output logic            rty_o
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned OFF   = (NB > 1) ? $clog2(NB) : 0;
  localparam int unsigned IW    = DEPTH_LOG2;
  localparam int unsigned TOP   = OFF + DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [AW-1:0] BASE = AW'(BASE_ADR);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_BURST = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  logic [DW-1:0] mem [DEPTH];

  logic [2:0]    state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [IW-1:0] beat, beat_n, next_b, idx, rd_idx, wrap_mask;
  logic          hit;
  logic          unused_adr;

  assign idx        = adr_i[TOP-1:OFF];
  assign hit        = (adr_i >> TOP) == (BASE >> TOP);
  assign unused_adr = ^adr_i;

  // Burst acks follow stb_i/cyc_i in the same cycle; the first beat is a registered state.
  assign ack_o = (state == S_ACK) || ((state == S_BURST) && cyc_i && stb_i);
  assign err_o = (state == S_ERR);
  assign rty_o = 1'b0;

  // Wrap bursts keep the upper index bits and roll the low log2(N) bits.
  always_comb begin
    wrap_mask = '1;
    case (bte_i)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '1;
    endcase
    next_b = (beat & ~wrap_mask) | ((beat + IW'(1)) & wrap_mask);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    beat_n  = beat;
    rd_idx  = beat;
    case (state)
      S_IDLE: begin
        beat_n = idx;
        rd_idx = idx;
        if (cyc_i && stb_i) begin
          if (!hit || (sel_i == '0)) begin
            state_n = S_ERR;
          end else if (WAIT_STATES > 0) begin
            state_n = S_WAIT;
            cnt_n   = 4'(WAIT_STATES);
          end else begin
            state_n = S_ACK;
          end
        end
      end
      S_WAIT: begin
        beat_n = idx;
        rd_idx = idx;
        if (!(cyc_i && stb_i)) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) state_n = S_ACK;
        end
      end
      S_ACK: begin
        beat_n = next_b;
        rd_idx = next_b;
        if ((BURST_EN != 0) && cyc_i && (cti_i == CTI_INC)) state_n = S_BURST;
        else                                                state_n = S_IDLE;
      end
      S_BURST: begin
        if (!cyc_i) begin
          state_n = S_IDLE;
        end else if (stb_i) begin
          beat_n = next_b;
          rd_idx = next_b;
          if ((cti_i == CTI_END) || (cti_i == CTI_CLASSIC)) state_n = S_IDLE;
        end
      end
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      beat  <= '0;
      dat_o <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      beat  <= beat_n;
      dat_o <= mem[rd_idx];
    end
  end

  // Byte-lane write commits on the acked edge.
  always_ff @(posedge clk) begin
    if (ack_o && we_i) begin
      for (int k = 0; k < NB; k++) begin
        if (sel_i[k]) mem[beat][8*k +: 8] <= dat_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wbs_mem_burst.sv
// Randomized bench for wbs_mem_burst: two instances (0 and 3 wait states) against a
// word-level memory model with explicit burst address sequencing.
module tb_wbs_mem_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr   [2];
  logic [31:0] dat_w [2];
  logic [31:0] dat_r [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic [2:0]  cti   [2];
  logic [1:0]  bte   [2];
  logic        ack   [2];
  logic        err   [2];
  logic        rty   [2];

  int          n_cmp;
  int          n_bad;
  logic [31:0] model [int];
  logic [31:0] obs   [16];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  wbs_mem_burst #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .adr_i(adr[0]), .dat_i(dat_w[0]), .dat_o(dat_r[0]),
    .we_i(we[0]), .sel_i(sel[0]), .cyc_i(cyc[0]), .stb_i(stb[0]), .cti_i(cti[0]),
    .bte_i(bte[0]), .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0])
  );

  wbs_mem_burst #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .adr_i(adr[1]), .dat_i(dat_w[1]), .dat_o(dat_r[1]),
    .we_i(we[1]), .sel_i(sel[1]), .cyc_i(cyc[1]), .stb_i(stb[1]), .cti_i(cti[1]),
    .bte_i(bte[1]), .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wsof(input int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic int key(input int i, input int unsigned idx);
    return i * 65536 + int'(idx);
  endfunction

  function automatic void mwrite(input int i, input int unsigned idx, input logic [31:0] d,
                                 input logic [3:0] s);
    logic [31:0] v;
    int kk;
    kk = key(i, idx);
    v  = model.exists(kk) ? model[kk] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    model[kk] = v;
  endfunction

  // Next word of a burst: linear over the whole 16K-word array, wrapN within aligned blocks of N.
  function automatic int unsigned ref_next(input int unsigned idx, input logic [1:0] b);
    int unsigned n;
    if (b == 2'b00) return (idx + 1) % 16384;
    n = (b == 2'b01) ? 4 : (b == 2'b10) ? 8 : 16;
    return idx - (idx % n) + ((idx % n) + 1) % n;
  endfunction

  task automatic idle_bus(input int i);
    cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; cti[i] = 3'b000; bte[i] = 2'b00;
  endtask

  task automatic classic(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input string tag);
    bit          hit;
    int          c, lat;
    logic        ackv, errv;
    logic [31:0] rd;
    hit = (a < 32'h0001_0000) && (s != 4'h0);
    lat = hit ? 1 + wsof(i) : 1;
    @(posedge clk); #1;
    adr[i] = a; dat_w[i] = d; sel[i] = s; we[i] = w; cti[i] = 3'b000; bte[i] = 2'b00;
    cyc[i] = 1'b1; stb[i] = 1'b1;
    c = 0; ackv = 1'b0; errv = 1'b0; rd = '0;
    while (c < 40) begin
      @(negedge clk);
      ackv = ack[i]; errv = err[i]; rd = dat_r[i];
      if (ackv || errv) break;
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_ack"}, 64'(ackv), 64'(hit));
    check({tag, "_err"}, 64'(errv), 64'(!hit));
    check({tag, "_lat"}, 64'(c), 64'(lat));
    if (hit && w) mwrite(i, a[15:2], d, s);
    if (hit && !w) begin
      last_rd = rd;
      check({tag, "_rd"}, 64'(rd), 64'(model[key(i, a[15:2])]));
    end
    @(posedge clk); #1;
    idle_bus(i);
    @(negedge clk);
    check({tag, "_gap"}, 64'({ack[i], err[i]}), 64'(0));
  endtask

  task automatic burst(input int i, input bit w, input int unsigned start, input logic [1:0] b,
                       input int n, input int gap_at, input string tag);
    int unsigned seq [16];
    logic [31:0] dw  [16];
    int          k, c, gap, lat;
    logic        ackv;
    lat    = 1 + wsof(i);
    seq[0] = start;
    dw[0]  = $urandom;
    for (int j = 1; j < n; j++) begin
      seq[j] = ref_next(seq[j-1], b);
      dw[j]  = $urandom;
    end
    @(posedge clk); #1;
    adr[i] = start * 4; dat_w[i] = dw[0]; sel[i] = 4'hf; we[i] = w; bte[i] = b;
    cti[i] = (n == 1) ? 3'b111 : 3'b010;
    cyc[i] = 1'b1; stb[i] = 1'b1;
    k = 0; c = 0; gap = 0;
    while (k < n && c < 100) begin
      @(negedge clk);
      ackv = ack[i];
      if (k > 0)     check({tag, "_beat_ack"}, 64'(ackv), 64'(stb[i]));
      else if (ackv) check({tag, "_lat"}, 64'(c), 64'(lat));
      if (ackv) begin
        if (w) mwrite(i, seq[k], dw[k], 4'hf);
        else begin
          obs[k] = dat_r[i];
          check({tag, "_rd"}, 64'(dat_r[i]), 64'(model[key(i, seq[k])]));
        end
        k++;
      end
      @(posedge clk); #1;
      c++;
      if (k < n) begin
        if (k > 0 && k == gap_at && gap < 2) begin
          stb[i] = 1'b0;
          gap++;
        end else begin
          stb[i] = 1'b1;
        end
        cti[i]   = (k == n - 1) ? 3'b111 : 3'b010;
        dat_w[i] = dw[k];
      end
    end
    idle_bus(i);
    check({tag, "_beats"}, 64'(k), 64'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] t4_exp [4];
    logic [31:0] a;
    int          inst, c, seen;
    int unsigned widx;
    n_cmp = 0; n_bad = 0; last_rd = '0;
    t4_exp[0] = 32'd6; t4_exp[1] = 32'd7; t4_exp[2] = 32'd4; t4_exp[3] = 32'd5;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle_bus(i); adr[i] = '0; dat_w[i] = '0; sel[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_ack", 64'(ack[i]), 64'(0));
      check("rst_err", 64'(err[i]), 64'(0));
      check("rst_dat", 64'(dat_r[i]), 64'(0));
      check("rty",     64'(rty[i]), 64'(0));
    end
    rst = 1'b1;

    // Words 0..15 hold their own index; 16..63 random.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++)
        classic(i, 1'b1, 32'(j * 4), (j < 16) ? 32'(j) : $urandom, 4'hf, "pre");

    burst(0, 1'b0, 6, 2'b01, 4, -1, "t4");
    for (int j = 0; j < 4; j++) check("t4_const", 64'(obs[j]), 64'(t4_exp[j]));

    classic(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hf, "t1w");
    classic(0, 1'b0, 32'h10, 32'h0, 4'hf, "t1r");
    check("t1_const", 64'(last_rd), 64'(32'hDEADBEEF));

    classic(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, "t2w");
    classic(0, 1'b0, 32'h10, 32'h0, 4'hf, "t2r");
    check("t2_const", 64'(last_rd), 64'(32'hDEADBEAA));
    classic(0, 1'b1, 32'h10, 32'h5555_5555, 4'b0000, "t2e");
    classic(0, 1'b0, 32'h10, 32'h0, 4'hf, "t2r2");
    check("t2_unchanged", 64'(last_rd), 64'(32'hDEADBEAA));

    burst(0, 1'b1, 0, 2'b00, 8, 3, "t5");
    for (int j = 0; j < 8; j++) classic(0, 1'b0, 32'(j * 4), 32'h0, 4'hf, "t5r");

    classic(1, 1'b0, 32'h20, 32'h0, 4'hf, "t3r");
    @(posedge clk); #1;
    adr[1] = 32'h20; we[1] = 1'b0; sel[1] = 4'hf; cyc[1] = 1'b1; stb[1] = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("t3_drop_ack", 64'({ack[1], err[1]}), 64'(0));
      @(posedge clk); #1;
      if (j == 1) idle_bus(1);
    end
    classic(1, 1'b0, 32'h20, 32'h0, 4'hf, "t3r2");

    classic(0, 1'b0, 32'h0001_0000, 32'h0, 4'hf, "t6miss");
    @(posedge clk); #1;
    adr[0] = 32'd32; we[0] = 1'b0; sel[0] = 4'hf; cti[0] = 3'b010; bte[0] = 2'b00;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    c = 0; seen = 0;
    while (c < 20 && seen < 2) begin
      @(negedge clk);
      if (ack[0]) seen++;
      if (seen < 2) begin
        @(posedge clk); #1;
        c++;
      end
    end
    check("t6_pre_ack", 64'(ack[0]), 64'(1));
    #1 rst = 1'b0;
    #1;
    check("t6_rst_ack", 64'(ack[0]), 64'(0));
    check("t6_rst_err", 64'(err[0]), 64'(0));
    idle_bus(0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int j = 8; j < 12; j++) classic(0, 1'b0, 32'(j * 4), 32'h0, 4'hf, "t6ret");

    for (int t = 0; t < 150; t++) begin
      inst = int'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        burst(inst, 1'($urandom_range(0, 1)), $urandom_range(0, 55), 2'($urandom_range(0, 3)),
              int'($urandom_range(1, 8)), int'($urandom_range(1, 8)), "rb");
      end else begin
        widx = $urandom_range(0, 63);
        a    = 32'(widx * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | (32'h0001_0000 << $urandom_range(0, 15));
        classic(inst, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rc");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wbs_mem_burst.md
Name: wbs_mem_burst

Overview:
Parametrised Wishbone B3 slave memory, the successor to the fixed 64 KiB four-byte-lane slave. It adds configurable data width, depth, base address, wait states, registered-feedback incrementing/wrapping bursts and an error response for out-of-range or empty-select accesses. It sits on the system bus behind the intercon as on-chip RAM for instruction and data fetch.

Parameters:
DW, 32, data width in bits; 8, 16, 32 or 64; byte lanes NB = DW/8.
AW, 32, address width in bits; byte address.
DEPTH_LOG2, 14, log2 of the number of DW-bit words.
BASE_ADR, 0, byte base address; aligned to the region size NB << DEPTH_LOG2.
WAIT_STATES, 0, extra cycles before the first ack; 0..15.
BURST_EN, 1, 1 honours cti_i/bte_i; 0 treats every cycle as classic.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
adr_i  in  AW  byte address; bits [log2(NB)-1:0] ignored
dat_i  in  DW  write data; lane k = dat_i[8k+7:8k]
dat_o  out  DW  read data, valid only while ack_o=1
we_i  in  1  1 = write
sel_i  in  NB  byte-lane enables
cyc_i  in  1  bus cycle in progress
stb_i  in  1  strobe
cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
ack_o  out  1  normal termination
err_o  out  1  error termination
rty_o  out  1  retry; constant 0

Behaviour:
- Reset (rst=0, asynchronous): state to IDLE; ack_o, err_o, wait counter and beat address to 0; dat_o to 0. Memory contents are not cleared. Reset mid-transfer aborts the transfer and produces no further ack.
- Hit: cyc_i & stb_i & (adr_i[AW-1:log2(NB)+DEPTH_LOG2] == BASE_ADR upper bits). Word index = adr_i[log2(NB)+DEPTH_LOG2-1:log2(NB)].
- Memory: synchronous read, byte-lane write; only lanes with sel_i[k]=1 are written. A write is committed at the clock edge where ack_o=1 and we_i=1.
- State IDLE:
  - cyc&stb miss, or sel_i==0 → ERR.
  - Hit with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES.
  - Hit with WAIT_STATES=0 → ACK.
- WAIT: counter decrements each cycle; at 1 → ACK. cyc_i or stb_i low → IDLE, with no ack.
- ACK: ack_o=1 for exactly one cycle; dat_o holds word[index] (read) and the write commits.
  - If BURST_EN=1, cti_i=010 and cyc_i=1 → BURST, with the beat address advanced.
  - Otherwise → IDLE.
  - Classic cycles therefore ack at latency 1+WAIT_STATES and always drop ack for at least one cycle before the next access.
- BURST: ack_o=1 every cycle in which stb_i=1, with no wait states between beats.
  - stb_i=0: ack_o=0 and the address holds.
  - Next beat address: linear = index+1, wrapping at DEPTH; wrapN = upper bits held, low log2(N) bits incremented modulo N.
  - The read address is the next-beat address whenever ack&stb, so the following beat's data is valid on the next cycle.
  - Exit to IDLE after the acked beat where cti_i=111, or a beat acked with cti_i=000, or when cyc_i=0. cyc_i=0 drops ack_o in that same cycle.
  - The burst ignores adr_i after the first beat; a miss is not re-checked within a burst.
- ERR: err_o=1 for one cycle, with no memory access; then IDLE. err_o and ack_o are never both 1.
- Simultaneous: a new cyc&stb in the cycle after ack/err is ignored until IDLE is re-entered; it is sampled the following cycle.

Test Plan:
1. DW=32, WAIT_STATES=0: write 0xDEADBEEF at 0x10 (sel=1111), then read 0x10 → ack 1 cycle after stb on each access; read data 0xDEADBEEF; ack low ≥1 cycle between the two accesses.
2. Byte write 0x000000AA with sel=0001 at 0x10, then read → 0xDEADBEAA; with sel=0000 → err_o one cycle, memory unchanged.
3. WAIT_STATES=3: classic read → ack at cycle 4 after stb; drop stb at cycle 2 → no ack, state returns to IDLE.
4. Burst read, cti=010, bte=01 (wrap4), start 0x18, words preloaded as word index values → ack on 4 consecutive cycles; data 6,7,4,5; cti=111 on the 4th beat → IDLE.
5. Linear burst write of 8 beats from 0x0 with stb low for 2 cycles at beat 3 → ack gaps match the stb gaps; readback gives all 8 words correct.
6. Address 0x0001_0000 with BASE_ADR=0, DEPTH_LOG2=14 → err_o, no ack. Assert rst low mid-burst → ack_o and err_o 0 immediately; memory retains the previously written data.
